result_drain_packer: RTL and testbench

//  Downstream drain stage for the CNN core's result buffer. Pops results one at a time via the

---
 rtl/result_drain_packer.sv | 152 +++++++++++++++
 tb/tb_result_drain_packer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain_packer.sv
// rtl/result_drain_packer.sv - drains CNN result buffer, applies optional ReLU, packs results into addressed output words
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   start, num_results, relu_en job launch; parameters latched with start in IDLE
//   result_buffer_*             pop handshake toward the core result buffer
//   out_data/keep/addr/last     packed word, lane mask, word address, final-word flag
//   out_valid, out_ready        output word handshake
//   busy, done                  job in progress, one-cycle end-of-job pulse
module result_drain_packer #(
    parameter int RESULT_BUFFER_WIDTH = 8,
    parameter int PACK                = 4,
    parameter int CNT_WIDTH           = 16,
    parameter int OUT_ADDR_WIDTH      = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [CNT_WIDTH-1:0]                num_results,
    input  logic                                relu_en,
    input  logic [RESULT_BUFFER_WIDTH-1:0]      result_buffer_out,
    input  logic                                result_buffer_empty,
    input  logic                                result_buffer_valid,
    output logic                                result_buffer_read_enable,
    output logic [PACK*RESULT_BUFFER_WIDTH-1:0] out_data,
    output logic [PACK-1:0]                     out_keep,
    output logic [OUT_ADDR_WIDTH-1:0]           out_addr,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done
);

    localparam int RBW  = RESULT_BUFFER_WIDTH;
    localparam int IDXW = $clog2(PACK + 1);
    localparam logic [IDXW-1:0] PACK_IDX = IDXW'(PACK);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                  state;
    logic [PACK*RBW-1:0]     lanes;
    logic [PACK-1:0]         keep;
    logic [IDXW-1:0]         idx;
    logic [CNT_WIDTH-1:0]    remaining;
    logic                    relu_q;

    logic [IDXW-1:0]         idx_next;
    logic [CNT_WIDTH-1:0]    rem_next;
    logic [RBW-1:0]          lane_val;

    assign idx_next = idx + 1'b1;
    assign rem_next = remaining - 1'b1;
    assign lane_val = (relu_q && result_buffer_out[RBW-1]) ? '0 : result_buffer_out;

    // Pop is only requested from REQ, so WAIT guarantees a single outstanding pop.
    assign result_buffer_read_enable = (state == REQ) && !result_buffer_empty;
    assign out_data = lanes;
    assign out_keep = keep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lanes     <= '0;
            keep      <= '0;
            idx       <= '0;
            remaining <= '0;
            relu_q    <= 1'b0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= num_results;
                        relu_q    <= relu_en;
                        out_addr  <= '0;
                        lanes     <= '0;
                        keep      <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        if (num_results == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!result_buffer_empty) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (result_buffer_valid) begin
                        for (int i = 0; i < PACK; i++) begin
                            if (idx == IDXW'(i)) begin
                                lanes[i*RBW +: RBW] <= lane_val;
                                keep[i]             <= 1'b1;
                            end
                        end
                        idx       <= idx_next;
                        remaining <= rem_next;
                        if (idx_next == PACK_IDX || rem_next == '0) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_last  <= (rem_next == '0);
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_addr  <= out_addr + 1'b1;
                        lanes     <= '0;
                        keep      <= '0;
                        idx       <= '0;
                        if (remaining == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain_packer.sv
// tb/tb_result_drain_packer.sv - directed self-checking bench for result_drain_packer
module tb_result_drain_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_results;
    logic        relu_en;
    logic [7:0]  rb_data;
    logic        rb_empty;
    logic        rb_valid;
    logic        rd_en;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic [9:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    result_drain_packer dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .num_results               (num_results),
        .relu_en                   (relu_en),
        .result_buffer_out         (rb_data),
        .result_buffer_empty       (rb_empty),
        .result_buffer_valid       (rb_valid),
        .result_buffer_read_enable (rd_en),
        .out_data                  (out_data),
        .out_keep                  (out_keep),
        .out_addr                  (out_addr),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_last                  (out_last),
        .busy                      (busy),
        .done                      (done)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [7:0]  q[$];
    int          q_cnt = 0;
    logic        stall = 1'b0;
    logic        pop_req = 1'b0;
    assign rb_empty = stall || (q_cnt == 0);

    int rd_cnt, done_cnt, done_double, valid_cycles, underflow;
    logic        done_prev = 1'b0;
    logic [31:0] w_data[$];
    logic [3:0]  w_keep[$];
    logic [9:0]  w_addr[$];
    logic        w_last[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        pop_req = rd_en;
        if (rd_en) rd_cnt++;
        if (rd_en && q.size() == 0) underflow++;
        if (done) done_cnt++;
        if (done && done_prev) done_double++;
        done_prev = done;
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) begin
            w_data.push_back(out_data);
            w_keep.push_back(out_keep);
            w_addr.push_back(out_addr);
            w_last.push_back(out_last);
        end
    end

    // Result buffer model: a pop seen at an edge returns data valid for the following cycle.
    always @(posedge clk) begin
        #1;
        rb_valid = 1'b0;
        if (pop_req && q.size() > 0) begin
            rb_valid = 1'b1;
            rb_data  = q.pop_front();
        end
        q_cnt = q.size();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        rd_cnt = 0; done_cnt = 0; done_double = 0; valid_cycles = 0; underflow = 0;
        w_data.delete(); w_keep.delete(); w_addr.delete(); w_last.delete();
    endtask

    task automatic push(input logic [7:0] v);
        q.push_back(v);
        q_cnt = q.size();
    endtask

    task automatic start_job(input int n, input logic r);
        start = 1'b1; num_results = 16'(n); relu_en = r;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, (n < budget), 1'b1);
        repeat (3) tick();
    endtask

    task automatic wait_pops(input int k, input int budget);
        int n = 0;
        while (rd_cnt < k && n < budget) begin
            tick();
            n++;
        end
        check("pop_timeout", (n < budget), 1'b1);
    endtask

    task automatic check_word(input string tag, input int k, input logic [31:0] d,
                              input logic [3:0] kp, input logic [9:0] a, input logic l);
        logic [31:0] od = 'x;
        logic [3:0]  ok = 'x;
        logic [9:0]  oa = 'x;
        logic        ol = 1'bx;
        if (k < w_data.size()) begin
            od = w_data[k]; ok = w_keep[k]; oa = w_addr[k]; ol = w_last[k];
        end
        check({tag, "_data"}, od, d);
        check({tag, "_keep"}, ok, kp);
        check({tag, "_addr"}, oa, a);
        check({tag, "_last"}, ol, l);
    endtask

    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic [9:0]  s_addr;
    logic        s_last;
    int          unstable;
    int          snap;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_results = '0; relu_en = 1'b0;
        rb_data = '0; rb_valid = 1'b0; out_ready = 1'b1;
        clear_counts();
        repeat (3) tick();
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_keep", out_keep, 4'h0);
        check("rst_out_addr", out_addr, 10'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        tick();

        // Eight results, no ReLU, two full words.
        clear_counts();
        for (int i = 1; i <= 8; i++) push(8'(i));
        start_job(8, 1'b0);
        wait_done("a_done_timeout", 200);
        check("a_nwords", w_data.size(), 2);
        check_word("a_w0", 0, 32'h04030201, 4'hF, 10'd0, 1'b0);
        check_word("a_w1", 1, 32'h08070605, 4'hF, 10'd1, 1'b1);
        check("a_done_cnt", done_cnt, 1);
        check("a_done_width", done_double, 0);
        check("a_underflow", underflow, 0);
        check("a_busy_after", busy, 1'b0);

        // ReLU with a partial final word.
        clear_counts();
        push(8'hFD); push(8'h05); push(8'hFF); push(8'h07); push(8'h02); push(8'h80);
        start_job(6, 1'b1);
        wait_done("b_done_timeout", 200);
        check("b_nwords", w_data.size(), 2);
        check_word("b_w0", 0, 32'h07000500, 4'hF, 10'd0, 1'b0);
        check_word("b_w1", 1, 32'h00000002, 4'h3, 10'd1, 1'b1);
        check("b_done_cnt", done_cnt, 1);

        // Empty buffer for 10 cycles mid-job.
        clear_counts();
        for (int i = 1; i <= 8; i++) push(8'(i));
        start_job(8, 1'b0);
        wait_pops(3, 50);
        stall = 1'b1;
        snap = rd_cnt;
        repeat (10) tick();
        check("c_stall_pops", rd_cnt - snap, 0);
        stall = 1'b0;
        wait_done("c_done_timeout", 200);
        check("c_nwords", w_data.size(), 2);
        check_word("c_w0", 0, 32'h04030201, 4'hF, 10'd0, 1'b0);
        check_word("c_w1", 1, 32'h08070605, 4'hF, 10'd1, 1'b1);
        check("c_underflow", underflow, 0);

        // Backpressure on the output for 5 cycles.
        clear_counts();
        out_ready = 1'b0;
        push(8'd10); push(8'd20); push(8'd30); push(8'd40);
        start_job(4, 1'b0);
        snap = 0;
        while (!out_valid && snap < 50) begin
            tick();
            snap++;
        end
        check("d_valid_timeout", (snap < 50), 1'b1);
        s_data = out_data; s_keep = out_keep; s_addr = out_addr; s_last = out_last;
        snap = rd_cnt;
        unstable = 0;
        repeat (5) begin
            tick();
            if (out_data !== s_data || out_keep !== s_keep || out_addr !== s_addr ||
                out_last !== s_last || out_valid !== 1'b1) unstable++;
        end
        check("d_stable", unstable, 0);
        check("d_no_pops", rd_cnt - snap, 0);
        check("d_held_data", s_data, 32'h281E140A);
        out_ready = 1'b1;
        wait_done("d_done_timeout", 100);
        check("d_nwords", w_data.size(), 1);
        check_word("d_w0", 0, 32'h281E140A, 4'hF, 10'd0, 1'b1);

        // Zero-length job.
        clear_counts();
        start_job(0, 1'b0);
        wait_done("e_done_timeout", 10);
        check("e_done_cnt", done_cnt, 1);
        check("e_done_width", done_double, 0);
        check("e_rd_cnt", rd_cnt, 0);
        check("e_valid_cycles", valid_cycles, 0);

        // Reset while waiting for the third result of four.
        clear_counts();
        push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        start_job(4, 1'b0);
        wait_pops(3, 50);
        reset = 1'b1;
        #1;
        check("f_rd_en", rd_en, 1'b0);
        check("f_out_valid", out_valid, 1'b0);
        check("f_out_data", out_data, 32'h0);
        check("f_out_keep", out_keep, 4'h0);
        check("f_out_addr", out_addr, 10'h0);
        check("f_busy", busy, 1'b0);
        check("f_done", done, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        q.delete();
        q_cnt = 0;
        tick();
        check("f_no_done", done_cnt, 0);
        check("f_no_words", w_data.size(), 0);
        clear_counts();
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        start_job(4, 1'b0);
        wait_done("f_done_timeout", 100);
        check("f_nwords", w_data.size(), 1);
        check_word("f_w0", 0, 32'h24232221, 4'hF, 10'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
